instr_realigner: RTL and testbench

- Fetch-side controller between instruction memory and the RVC decompressor/decoder.
- Requests aligned 32-bit words and buffers them as halfwords.
- Extracts 16-bit and 32-bit instructions, including 32-bit instructions split across word boundaries.
- Presents each instruction with its PC and an is_compressed flag over a valid/ready handshake.
- Handles PC redirects (branch/jump/flush) by discarding buffered and in-flight data.

---
 rtl/instr_realigner_if.sv | 42 ++++
 rtl/instr_realigner.sv | 144 ++++++++++++++
 tb/tb_instr_realigner.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_realigner_if.sv
// Fetch-side bus bundle for the instruction realigner: the word-fetch
// request/response channel toward instruction memory, the redirect
// request, and the instruction stream toward decode.
interface instr_realigner_if #(
    parameter int ADDR_WIDTH = 32
);
    // Memory fetch channel
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    // Control-flow redirect
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    // Instruction stream toward decode
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic                  out_is_compressed;
    logic [ADDR_WIDTH-1:0] out_pc;

    // The realigner side: issues fetches and presents instructions
    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_is_compressed, out_pc,
        input  out_ready
    );

    // The environment side: memory, branch unit and decode
    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_is_compressed, out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_realigner.sv
// Instruction realigner: fetches aligned 32-bit words, keeps them as a
// four-deep halfword queue and hands out 16-bit (compressed) and 32-bit
// instructions, including 32-bit ones straddling a word boundary. A
// redirect flushes the queue and drops responses still in flight.
module instr_realigner #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input logic              clk,
    input logic              reset_n,
    instr_realigner_if.master bus
);

    localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int            NW      = OW + 3;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    // Registered state
    logic [15:0]           hw_buf [4];   // slot 0 is the oldest halfword
    logic [2:0]            count;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  drop_low;     // next kept response starts at its high half
    logic                  run;          // holds fetch off for the first cycle out of reset

    // Combinational next-state
    logic                  full_instr;
    logic                  out_valid;
    logic                  issue;
    logic                  granted;
    logic                  push;
    logic                  fire;
    logic [2:0]            pop_n;
    logic [2:0]            rem;
    logic [2:0]            count_nxt;
    logic [OW-1:0]         out_nxt;
    logic [NW-1:0]         need;
    logic [15:0]           buf_nxt [4];

    // Decide what sits at the head of the queue and whether it is complete
    always_comb begin
        full_instr = (hw_buf[0][1:0] == 2'b11);
        out_valid  = !bus.redirect &&
                     ((count >= 3'd2) || (!full_instr && (count != 3'd0)));
        bus.out_valid         = out_valid;
        bus.out_pc            = pc;
        bus.out_instr         = '0;
        bus.out_is_compressed = 1'b0;
        if (out_valid) begin
            bus.out_is_compressed = !full_instr;
            bus.out_instr         = full_instr ? {hw_buf[1], hw_buf[0]} : {16'h0000, hw_buf[0]};
        end
    end

    // Fetch issue: only ask for a word when its halfwords are guaranteed a slot
    always_comb begin
        need         = NW'(count) + (NW'(outstanding) << 1) + NW'(2);
        issue        = run && !bus.redirect && (need <= NW'(4)) && (outstanding < MAX_OUT);
        bus.mem_req  = issue;
        bus.mem_addr = fetch_addr;
        granted      = issue && bus.mem_gnt;
        out_nxt      = outstanding;
        if (granted && !bus.mem_rvalid) begin
            out_nxt = outstanding + OW'(1);
        end else if (!granted && bus.mem_rvalid) begin
            out_nxt = outstanding - OW'(1);
        end
    end

    // Queue update: pop the consumed halfwords, append the response behind the rest
    always_comb begin
        fire  = out_valid && bus.out_ready;
        push  = bus.mem_rvalid && (discard == '0) && !bus.redirect;
        pop_n = !fire ? 3'd0 : (full_instr ? 3'd2 : 3'd1);
        rem   = count - pop_n;
        for (int i = 0; i < 4; i++) begin
            buf_nxt[i] = hw_buf[i];
            if (i + int'(pop_n) < 4) begin
                buf_nxt[i] = hw_buf[2'(i + int'(pop_n))];
            end
        end
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == rem) begin
                    buf_nxt[i] = drop_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
                end else if (!drop_low && (3'(i) == rem + 3'd1)) begin
                    buf_nxt[i] = bus.mem_rdata[31:16];
                end
            end
        end
        count_nxt = rem + (!push ? 3'd0 : (drop_low ? 3'd1 : 3'd2));
    end

    // Control state: counters, PCs and the redirect flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= 3'd0;
            outstanding <= '0;
            discard     <= '0;
            fetch_addr  <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            pc          <= RESET_PC;
            drop_low    <= RESET_PC[1];
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_nxt;
            if (bus.redirect) begin
                count      <= 3'd0;
                pc         <= {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
                fetch_addr <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                drop_low   <= bus.redirect_pc[1];
                discard    <= out_nxt;
            end else begin
                count <= count_nxt;
                if (granted) begin
                    fetch_addr <= fetch_addr + ADDR_WIDTH'(4);
                end
                if (fire) begin
                    pc <= pc + (full_instr ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2));
                end
                if (push) begin
                    drop_low <= 1'b0;
                end
                if (bus.mem_rvalid && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
            end
        end
    end

    // Halfword storage; contents are meaningless beyond count, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            hw_buf[i] <= buf_nxt[i];
        end
    end

    // The issue rule leaves room for every response; a push into a nearly full queue is a bug
    assert property (@(posedge clk) disable iff (!reset_n) !(push && (count > 3'd2)));

endmodule

// File: tb/tb_instr_realigner.sv
// Directed bench for instr_realigner: in-order memory responder with
// configurable latency, an accept log of delivered instructions, and
// hand-computed expectations for each scenario.
module tb_instr_realigner;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_realigner_if #(.ADDR_WIDTH(32)) bus();

    instr_realigner #(
        .ADDR_WIDTH      (32),
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } rec_t;

    logic [31:0] mem [0:255];
    req_t        pend_q[$];
    rec_t        log_q[$];
    int          lat       = 1;
    int          cyc       = 0;
    int          grant_cnt = 0;
    int          max_pend  = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] instr, input logic comp);
        if (idx >= log_q.size()) begin
            chk({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            chk({tag, "_pc"},    log_q[idx].pc,          pc);
            chk({tag, "_instr"}, log_q[idx].instr,       instr);
            chk({tag, "_c"},     32'(log_q[idx].comp),   32'(comp));
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (log_q.size() < n) chk("log_timeout", 32'(log_q.size()), 32'(n));
    endtask

    task automatic wait_req(input int budget);
        logic ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        #1;
        chk("redir_out_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_mem_req",   32'(bus.mem_req),   32'd0);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        grant_cnt    = 0;
        log_q.delete();
    endtask

    // In-order memory: grants sampled late in the cycle, data returned lat cycles later
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                pend_q.delete();
            end else if (bus.mem_req && bus.mem_gnt) begin
                pend_q.push_back('{bus.mem_addr, cyc + lat});
                grant_cnt++;
                if (pend_q.size() > max_pend) max_pend = pend_q.size();
            end
            @(posedge clk);
            #1;
            cyc++;
            if (reset_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem[pend_q[0].addr[9:2]];
                void'(pend_q.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Accept log of every instruction handed to decode
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && bus.out_valid && bus.out_ready) begin
                log_q.push_back('{bus.out_pc, bus.out_instr, bus.out_is_compressed});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench stalled");
    end

    initial begin
        reset_n         = 1'b0;
        bus.mem_gnt     = 1'b1;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h0001_0001;
        mem[1] = 32'h0001_0001;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid),         32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),           32'd0);
        chk("rst_out_instr", bus.out_instr,              32'h0);
        chk("rst_out_c",     32'(bus.out_is_compressed), 32'd0);
        chk("rst_out_pc",    bus.out_pc,                 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Four c.nop from two words
        wait_log(4, 40);
        for (int i = 0; i < 4; i++) check_rec($sformatf("t1_%0d", i), i, 32'(2 * i), 32'h1, 1'b1);

        // c.nop followed by addi straddling the word boundary
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h0000_0000;
        do_redirect(32'h0);
        wait_req(20);
        chk("t2_addr0", bus.mem_addr, 32'h0);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t2_partial_count", 32'(log_q.size()), 32'd1);
        check_rec("t2_cnop", 0, 32'h0, 32'h1, 1'b1);
        chk("t2_partial_valid", 32'(bus.out_valid), 32'd0);
        chk("t2_partial_pc",    bus.out_pc,         32'h2);
        bus.mem_gnt = 1'b1;
        wait_log(3, 30);
        check_rec("t2_addi", 1, 32'h2, 32'h13, 1'b0);
        check_rec("t2_next", 2, 32'h6, 32'h0,  1'b1);

        // Backpressure with all 32-bit code
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
        do_redirect(32'h0);
        max_pend = 0;
        repeat (10) @(negedge clk);
        #1;
        chk("t3_grants",    32'(grant_cnt),       32'd2);
        chk("t3_max_pend",  32'(max_pend <= 2),   32'd1);
        chk("t3_req_full",  32'(bus.mem_req),     32'd0);
        chk("t3_valid",     32'(bus.out_valid),   32'd1);
        chk("t3_instr",     bus.out_instr,        32'h13);
        chk("t3_pc",        bus.out_pc,           32'h0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_log(3, 30);
        check_rec("t3_s0", 0, 32'h0, 32'h13, 1'b0);
        check_rec("t3_s1", 1, 32'h4, 32'h13, 1'b0);
        check_rec("t3_s2", 2, 32'h8, 32'h13, 1'b0);

        // Redirect to 0x102 with two requests in flight
        mem[64] = 32'h0001_0013;
        mem[65] = 32'h0000_0013;
        lat = 4;
        begin
            logic found = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                #1;
                if (pend_q.size() == 2) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("t4_two_inflight", 32'(found), 32'd1);
        end
        do_redirect(32'h102);
        wait_req(20);
        chk("t4_addr", bus.mem_addr, 32'h100);
        wait_log(2, 60);
        check_rec("t4_first",  0, 32'h102, 32'h1,  1'b1);
        check_rec("t4_second", 1, 32'h104, 32'h13, 1'b0);
        lat = 1;

        // Grant withheld: address holds, nothing to present
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        mem[128] = 32'h0001_0001;
        do_redirect(32'h200);
        repeat (6) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5_req_%0d", k),   32'(bus.mem_req),   32'd1);
            chk($sformatf("t5_addr_%0d", k),  bus.mem_addr,       32'h200);
            chk($sformatf("t5_valid_%0d", k), 32'(bus.out_valid), 32'd0);
        end
        bus.mem_gnt = 1'b1;
        wait_log(2, 30);
        check_rec("t5_s0", 0, 32'h200, 32'h1, 1'b1);
        check_rec("t5_s1", 1, 32'h202, 32'h1, 1'b1);

        // Asynchronous reset in the middle of the stream
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_mem_req",   32'(bus.mem_req),   32'd0);
        chk("t6_out_pc",    bus.out_pc,         32'h0);
        chk("t6_out_instr", bus.out_instr,      32'h0);
        log_q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        wait_req(10);
        chk("t6_addr", bus.mem_addr, 32'h0);
        wait_log(1, 20);
        check_rec("t6_first", 0, 32'h0, 32'h13, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
